// File: rtl/fetch_mem_unit.sv
// Fetch/memory-access unit for the multicycle core: PC, IR and MDR registers,
// plus a RUN/WAIT/ERR handshake FSM that stalls the controller and raises a sticky bus error on timeout.
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pcwrite,
    input  logic        i_branch,
    input  logic        i_irwrite,
    input  logic        i_iord,
    input  logic        i_memwrite,
    input  logic [1:0]  i_pcsrc,
    input  logic        i_zero,
    input  logic [31:0] i_aluresult,
    input  logic [31:0] i_aluout,
    input  logic [31:0] i_memrdata,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_mdr,
    output logic [5:0]  o_op,
    output logic [5:0]  o_funct,
    output logic        o_stall,
    output logic        o_bus_err,
    output logic [31:0] o_instr_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_mdr;
    logic [31:0] r_instr_count;
    logic        r_bus_err;
    logic [31:0] w_pcnext;
    logic        w_access;
    logic        w_in_err;
    logic        w_stall;
    logic        w_pcen;
    logic        w_ir_load;
    logic        w_mdr_load;

    assign w_access   = i_irwrite | i_iord;
    assign w_in_err   = (r_state == ST_ERR);
    assign w_stall    = (w_access & ~i_mem_ready) | w_in_err;
    assign w_pcen     = (i_pcwrite | (i_branch & i_zero)) & ~w_stall;
    assign w_ir_load  = i_irwrite & i_mem_ready & ~w_in_err;
    assign w_mdr_load = i_iord & ~i_memwrite & i_mem_ready & ~w_in_err;

    assign o_mem_req     = w_access & ~w_in_err;
    assign o_mem_we      = i_memwrite & i_iord & o_mem_req;
    assign o_mem_addr    = i_iord ? i_aluout : r_pc;
    assign o_stall       = w_stall;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_mdr         = r_mdr;
    assign o_op          = r_instr[31:26];
    assign o_funct       = r_instr[5:0];
    assign o_bus_err     = r_bus_err;
    assign o_instr_count = r_instr_count;

    // Next-PC select; the jump target is built from the IR contents before any same-cycle load
    always_comb begin
        w_pcnext = r_pc;
        case (i_pcsrc)
            2'b00:   w_pcnext = i_aluresult;
            2'b01:   w_pcnext = i_aluout;
            2'b10:   w_pcnext = {r_pc[31:28], r_instr[25:0], 2'b00};
            2'b11:   w_pcnext = r_pc;
            default: w_pcnext = r_pc;
        endcase
    end

    // Access FSM next state and wait counter; a dropped strobe in WAIT abandons the access
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_access & ~i_mem_ready) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (~w_access | i_mem_ready) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == TIMEOUT_C) begin
                    w_state_nxt = ST_ERR;
                    w_cnt_nxt   = r_cnt;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
                w_cnt_nxt   = r_cnt;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // FSM state, wait counter and sticky bus error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_cnt     <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bus_err <= (w_state_nxt == ST_ERR);
        end
    end

    // Architectural registers: PC, IR, MDR and fetch counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_mdr         <= 32'h0000_0000;
            r_instr_count <= 32'h0000_0000;
        end else begin
            if (w_pcen) begin
                r_pc <= w_pcnext;
            end else begin
                r_pc <= r_pc;
            end
            if (w_ir_load) begin
                r_instr       <= i_memrdata;
                r_instr_count <= r_instr_count + 32'd1;
            end else begin
                r_instr       <= r_instr;
                r_instr_count <= r_instr_count;
            end
            if (w_mdr_load) begin
                r_mdr <= i_memrdata;
            end else begin
                r_mdr <= r_mdr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Self-checking bench for fetch_mem_unit: scenario tasks with a queue scoreboard for IR/MDR loads.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcwrite, branch, irwrite, iord, memwrite, zero, mem_ready;
    logic [1:0]  pcsrc;
    logic [31:0] aluresult, aluout, memrdata;
    logic        mem_req, mem_we, stall, bus_err;
    logic [31:0] mem_addr, pc, instr, mdr, instr_count;
    logic [5:0]  op, funct;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] instr_q[$];
    logic [31:0] mdr_q[$];
    logic [31:0] exp_v;
    logic [31:0] m_pc, m_instr, m_mdr, m_count;

    fetch_mem_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .i_pcwrite(pcwrite), .i_branch(branch), .i_irwrite(irwrite), .i_iord(iord),
        .i_memwrite(memwrite), .i_pcsrc(pcsrc), .i_zero(zero),
        .i_aluresult(aluresult), .i_aluout(aluout), .i_memrdata(memrdata),
        .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_pc(pc), .o_instr(instr), .o_mdr(mdr), .o_op(op), .o_funct(funct),
        .o_stall(stall), .o_bus_err(bus_err), .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        pcwrite = 1'b0; branch = 1'b0; irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0;
        zero = 1'b0; mem_ready = 1'b0; pcsrc = 2'b11;
        aluresult = 32'h0; aluout = 32'h0; memrdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        repeat (2) tick();
        total_cnt++; if (pc !== 32'h0) $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0 || mdr !== 32'h0) $display("FAIL rst_ir_mdr got=%h/%h exp=0/0", instr, mdr); else pass_cnt++;
        total_cnt++; if (instr_count !== 32'h0 || bus_err !== 1'b0) $display("FAIL rst_cnt_err got=%h/%b exp=0/0", instr_count, bus_err); else pass_cnt++;
        total_cnt++; if (op !== 6'h0 || funct !== 6'h0) $display("FAIL rst_op_funct got=%h/%h exp=0/0", op, funct); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rst_idle got=%b/%b exp=0/0", mem_req, stall); else pass_cnt++;
        irwrite = 1'b1;
        #1;
        total_cnt++; if (mem_req !== 1'b1 || stall !== 1'b1) $display("FAIL rst_follow got=%b/%b exp=1/1", mem_req, stall); else pass_cnt++;
        set_idle();
        reset = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_mdr = 32'h0; m_count = 32'h0;
        #1;
    endtask

    task automatic test_zero_wait_fetch();
        irwrite = 1'b1; pcwrite = 1'b1; pcsrc = 2'b00; aluresult = 32'h4;
        mem_ready = 1'b1; memrdata = 32'h8C22_0004;
        instr_q.push_back(32'h8C22_0004);
        #1;
        total_cnt++; if (stall !== 1'b0 || mem_addr !== 32'h0) $display("FAIL zw_comb got=%b/%h exp=0/%h", stall, mem_addr, 32'h0); else pass_cnt++;
        tick();
        set_idle();
        exp_v = instr_q.pop_front();
        total_cnt++; if (instr !== exp_v) $display("FAIL zw_instr got=%h exp=%h", instr, exp_v); else pass_cnt++;
        total_cnt++; if (op !== 6'b100011 || funct !== 6'h04) $display("FAIL zw_op got=%b/%h exp=100011/04", op, funct); else pass_cnt++;
        total_cnt++; if (pc !== 32'h4 || instr_count !== 32'd1) $display("FAIL zw_pc_cnt got=%h/%0d exp=4/1", pc, instr_count); else pass_cnt++;
        m_pc = 32'h4; m_instr = exp_v; m_count = 32'd1;
    endtask

    task automatic test_wait_fetch();
        irwrite = 1'b1; pcwrite = 1'b1; pcsrc = 2'b00; aluresult = 32'h8;
        mem_ready = 1'b0; memrdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (stall !== 1'b1 || mem_req !== 1'b1) $display("FAIL wt_stall%0d got=%b/%b exp=1/1", i, stall, mem_req); else pass_cnt++;
            tick();
            total_cnt++; if (pc !== m_pc || instr !== m_instr) $display("FAIL wt_hold%0d got=%h/%h exp=%h/%h", i, pc, instr, m_pc, m_instr); else pass_cnt++;
        end
        mem_ready = 1'b1; memrdata = 32'hAC43_0008;
        instr_q.push_back(32'hAC43_0008);
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL wt_release got=%b exp=0", stall); else pass_cnt++;
        tick();
        set_idle();
        exp_v = instr_q.pop_front();
        total_cnt++; if (instr !== exp_v) $display("FAIL wt_instr got=%h exp=%h", instr, exp_v); else pass_cnt++;
        total_cnt++; if (pc !== 32'h8 || instr_count !== m_count + 32'd1) $display("FAIL wt_pc_cnt got=%h/%0d exp=8/%0d", pc, instr_count, m_count + 32'd1); else pass_cnt++;
        tick();
        total_cnt++; if (instr_count !== m_count + 32'd1) $display("FAIL wt_single got=%0d exp=%0d", instr_count, m_count + 32'd1); else pass_cnt++;
        m_pc = 32'h8; m_instr = exp_v; m_count = m_count + 32'd1;
    endtask

    task automatic test_branch_jump();
        branch = 1'b1; zero = 1'b0; pcsrc = 2'b01; aluout = 32'h40;
        tick();
        total_cnt++; if (pc !== m_pc) $display("FAIL br_nottaken got=%h exp=%h", pc, m_pc); else pass_cnt++;
        zero = 1'b1;
        tick();
        total_cnt++; if (pc !== 32'h40) $display("FAIL br_taken got=%h exp=%h", pc, 32'h40); else pass_cnt++;
        set_idle();
        pcwrite = 1'b1; pcsrc = 2'b00; aluresult = 32'h1000_0000;
        irwrite = 1'b1; mem_ready = 1'b1; memrdata = 32'h0800_0010;
        instr_q.push_back(32'h0800_0010);
        tick();
        exp_v = instr_q.pop_front();
        total_cnt++; if (instr !== exp_v || pc !== 32'h1000_0000) $display("FAIL jmp_setup got=%h/%h exp=%h/%h", instr, pc, exp_v, 32'h1000_0000); else pass_cnt++;
        pcsrc = 2'b10; memrdata = 32'h0BFF_FFFF;
        instr_q.push_back(32'h0BFF_FFFF);
        tick();
        set_idle();
        exp_v = instr_q.pop_front();
        total_cnt++; if (pc !== 32'h1000_0040) $display("FAIL jmp_pc got=%h exp=%h", pc, 32'h1000_0040); else pass_cnt++;
        total_cnt++; if (instr !== exp_v || instr_count !== m_count + 32'd2) $display("FAIL jmp_ir got=%h/%0d exp=%h/%0d", instr, instr_count, exp_v, m_count + 32'd2); else pass_cnt++;
        m_pc = 32'h1000_0040; m_instr = exp_v; m_count = m_count + 32'd2;
    endtask

    task automatic test_load_store();
        iord = 1'b1; memwrite = 1'b0; aluout = 32'h20; memrdata = 32'hDEAD_BEEF; mem_ready = 1'b1;
        mdr_q.push_back(32'hDEAD_BEEF);
        #1;
        total_cnt++; if (mem_addr !== 32'h20 || mem_we !== 1'b0) $display("FAIL ld_addr got=%h/%b exp=%h/0", mem_addr, mem_we, 32'h20); else pass_cnt++;
        tick();
        exp_v = mdr_q.pop_front();
        total_cnt++; if (mdr !== exp_v) $display("FAIL ld_mdr got=%h exp=%h", mdr, exp_v); else pass_cnt++;
        memwrite = 1'b1; memrdata = 32'h0000_1111; aluout = 32'h24;
        #1;
        total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h24) $display("FAIL st_we got=%b/%h exp=1/%h", mem_we, mem_addr, 32'h24); else pass_cnt++;
        tick();
        set_idle();
        total_cnt++; if (mdr !== exp_v || instr !== m_instr || instr_count !== m_count) $display("FAIL st_hold got=%h/%h/%0d exp=%h/%h/%0d", mdr, instr, instr_count, exp_v, m_instr, m_count); else pass_cnt++;
        m_mdr = exp_v;
    endtask

    task automatic test_strobe_drop();
        irwrite = 1'b1; mem_ready = 1'b0;
        tick();
        set_idle();
        #1;
        total_cnt++; if (stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL drop_comb got=%b/%b exp=0/0", stall, mem_req); else pass_cnt++;
        tick();
        irwrite = 1'b1; mem_ready = 1'b0;
        repeat (4) tick();
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL drop_noerr got=%b exp=0", bus_err); else pass_cnt++;
        mem_ready = 1'b1; memrdata = 32'h0123_4567;
        instr_q.push_back(32'h0123_4567);
        tick();
        set_idle();
        exp_v = instr_q.pop_front();
        total_cnt++; if (instr !== exp_v || instr_count !== m_count + 32'd1) $display("FAIL drop_fetch got=%h/%0d exp=%h/%0d", instr, instr_count, exp_v, m_count + 32'd1); else pass_cnt++;
        m_instr = exp_v; m_count = m_count + 32'd1;
    endtask

    task automatic test_timeout();
        irwrite = 1'b1; mem_ready = 1'b0;
        repeat (4) tick();
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL to_early got=%b exp=0", bus_err); else pass_cnt++;
        tick();
        total_cnt++; if (bus_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b1) $display("FAIL to_err got=%b/%b/%b exp=1/0/1", bus_err, mem_req, stall); else pass_cnt++;
        mem_ready = 1'b1; pcwrite = 1'b1; pcsrc = 2'b00; aluresult = 32'h0000_0abc; memrdata = 32'h7777_7777;
        repeat (2) tick();
        total_cnt++; if (pc !== m_pc || instr !== m_instr || instr_count !== m_count) $display("FAIL to_frozen got=%h/%h/%0d exp=%h/%h/%0d", pc, instr, instr_count, m_pc, m_instr, m_count); else pass_cnt++;
        set_idle();
        #1;
        total_cnt++; if (stall !== 1'b1 || bus_err !== 1'b1) $display("FAIL to_sticky got=%b/%b exp=1/1", stall, bus_err); else pass_cnt++;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        total_cnt++; if (bus_err !== 1'b0 || stall !== 1'b0 || pc !== 32'h0) $display("FAIL to_reset got=%b/%b/%h exp=0/0/0", bus_err, stall, pc); else pass_cnt++;
        m_pc = 32'h0; m_instr = 32'h0; m_mdr = 32'h0; m_count = 32'h0;
    endtask

    task automatic test_wrap();
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        irwrite = 1'b1; mem_ready = 1'b1; memrdata = 32'h2002_0001;
        instr_q.push_back(32'h2002_0001);
        tick();
        set_idle();
        exp_v = instr_q.pop_front();
        total_cnt++; if (instr_count !== 32'h0 || instr !== exp_v) $display("FAIL wrap got=%h/%h exp=0/%h", instr_count, instr, exp_v); else pass_cnt++;
        m_instr = exp_v; m_count = 32'h0;
    endtask

    task automatic test_mid_reset();
        irwrite = 1'b1; pcwrite = 1'b1; pcsrc = 2'b00; aluresult = 32'h44; mem_ready = 1'b0;
        repeat (2) tick();
        mem_ready = 1'b1; memrdata = 32'h5555_5555;
        reset = 1'b1;
        #1;
        total_cnt++; if (pc !== 32'h0 || instr !== 32'h0) $display("FAIL mr_async got=%h/%h exp=0/0", pc, instr); else pass_cnt++;
        tick();
        total_cnt++; if (instr !== 32'h0 || instr_count !== 32'h0 || pc !== 32'h0) $display("FAIL mr_noload got=%h/%0d/%h exp=0/0/0", instr, instr_count, pc); else pass_cnt++;
        set_idle();
        reset = 1'b0;
        #1;
        irwrite = 1'b1; mem_ready = 1'b1; memrdata = 32'h3C01_0010;
        instr_q.push_back(32'h3C01_0010);
        #1;
        total_cnt++; if (stall !== 1'b0 || bus_err !== 1'b0) $display("FAIL mr_run got=%b/%b exp=0/0", stall, bus_err); else pass_cnt++;
        tick();
        set_idle();
        exp_v = instr_q.pop_front();
        total_cnt++; if (instr !== exp_v || instr_count !== 32'd1) $display("FAIL mr_fetch got=%h/%0d exp=%h/1", instr, instr_count, exp_v); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_wait_fetch();
        test_branch_jump();
        test_load_store();
        test_strobe_drop();
        test_timeout();
        test_wrap();
        test_mid_reset();
        total_cnt++; if (instr_q.size() != 0 || mdr_q.size() != 0) $display("FAIL sb_drain got=%0d/%0d exp=0/0", instr_q.size(), mdr_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
